// File: rtl/br_wrr_state_internal_if.sv
// Bus between a priority-mask arbiter and its weighted round-robin state block.
//   master : arbiter side; drives weight, update_priority, grant, burst_clear and
//            reads last_grant, priority_mask, burst_active, burst_remaining.
//   slave  : state block side (br_wrr_state_internal).
interface br_wrr_state_internal_if #(
  parameter int NumRequesters = 2,
  parameter int WeightWidth   = 4
);
  logic [NumRequesters*WeightWidth-1:0] weight;
  logic                                 update_priority;
  logic [NumRequesters-1:0]             grant;
  logic                                 burst_clear;
  logic [NumRequesters-1:0]             last_grant;
  logic [NumRequesters-1:0]             priority_mask;
  logic                                 burst_active;
  logic [WeightWidth-1:0]               burst_remaining;

  modport master (
    output weight, update_priority, grant, burst_clear,
    input  last_grant, priority_mask, burst_active, burst_remaining
  );

  modport slave (
    input  weight, update_priority, grant, burst_clear,
    output last_grant, priority_mask, burst_active, burst_remaining
  );
endinterface

// File: rtl/br_wrr_state_internal.sv
// Weighted round-robin priority state for a priority-mask arbiter.
// Holds a one-hot last-grant pointer and a burst credit counter so that
// requester i can win weight[i]+1 consecutive grants while it keeps requesting.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of br_wrr_state_internal_if
//          in : weight (packed per requester), update_priority, grant (one-hot),
//               burst_clear
//          out: last_grant, priority_mask (thermometer, 1 = low priority group),
//               burst_active, burst_remaining
// All outputs are decoded from the two state registers only.

// Property checker for the state block; contains no synthesizable logic.
module br_wrr_state_internal_chk #(
  parameter int NumRequesters = 2,
  parameter int WeightWidth   = 4
) (
  input logic                     clk,
  input logic                     rst,
  input logic                     update_priority,
  input logic [NumRequesters-1:0] grant,
  input logic [NumRequesters-1:0] last_grant,
  input logic [NumRequesters-1:0] priority_mask,
  input logic                     burst_active,
  input logic [WeightWidth-1:0]   credit
);
  if (NumRequesters < 2) begin : g_bad_num_requesters
    $error("br_wrr_state_internal: NumRequesters must be >= 2");
  end

  if (WeightWidth < 1) begin : g_bad_weight_width
    $error("br_wrr_state_internal: WeightWidth must be >= 1");
  end

  logic [NumRequesters:0] mask_ext_s;
  assign mask_ext_s = {1'b0, priority_mask};

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
    update_priority |-> $onehot(grant));

  a_last_grant_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot(last_grant));

  // A thermometer mask is a run of ones from bit 0: adding one clears them all.
  a_mask_thermometer: assert property (@(posedge clk) disable iff (rst)
    ((mask_ext_s + {{NumRequesters{1'b0}}, 1'b1}) & mask_ext_s) == '0);

  a_burst_active: assert property (@(posedge clk) disable iff (rst)
    burst_active == (credit != '0));
endmodule

module br_wrr_state_internal #(
  parameter int NumRequesters = 2,
  parameter int WeightWidth   = 4
) (
  input logic                         clk,
  input logic                         rst,
  br_wrr_state_internal_if.slave      bus
);
  localparam int IdxW = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;

  // One-hot to binary; OR-reduction form since the input is one-hot.
  function automatic logic [IdxW-1:0] onehot_to_idx(input logic [NumRequesters-1:0] v);
    logic [IdxW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NumRequesters; i++) begin
      idx = v[i] ? (idx | IdxW'(i)) : idx;
    end
    return idx;
  endfunction

  logic [NumRequesters-1:0] last_grant_r;
  logic [WeightWidth-1:0]   credit_r;
  logic [NumRequesters-1:0] last_grant_next_s;
  logic [WeightWidth-1:0]   credit_next_s;
  logic [IdxW-1:0]          k_s;
  logic [IdxW-1:0]          j_s;
  logic [WeightWidth-1:0]   weight_sel_s;
  logic                     burst_active_s;
  logic [NumRequesters-1:0] priority_mask_s;

  assign k_s            = onehot_to_idx(last_grant_r);
  assign j_s            = onehot_to_idx(bus.grant);
  assign weight_sel_s   = bus.weight[j_s*WeightWidth +: WeightWidth];
  assign burst_active_s = (credit_r != '0);

  // Priority mask: the holder of an active burst stays in the high group,
  // otherwise priority starts just after the last winner.
  always_comb begin
    priority_mask_s = '0;
    for (int i = 0; i < NumRequesters; i++) begin
      if (burst_active_s) begin
        priority_mask_s[i] = (IdxW'(i) < k_s);
      end else begin
        priority_mask_s[i] = (IdxW'(i) <= k_s);
      end
    end
  end

  // Next-state: continue or start a burst on a qualified grant, then apply clear.
  always_comb begin
    last_grant_next_s = last_grant_r;
    credit_next_s     = credit_r;
    if (bus.update_priority) begin
      if ((j_s == k_s) && burst_active_s) begin
        credit_next_s = credit_r - WeightWidth'(1'b1);
      end else begin
        last_grant_next_s = bus.grant;
        credit_next_s     = weight_sel_s;
      end
    end else begin
      credit_next_s = credit_r;
    end
    if (bus.burst_clear) begin
      credit_next_s = '0;
    end else begin
      credit_next_s = credit_next_s;
    end
  end

  // State registers; reset points the pointer at the last requester so
  // requester 0 has top priority first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_r <= {1'b1, {(NumRequesters-1){1'b0}}};
      credit_r     <= '0;
    end else begin
      last_grant_r <= last_grant_next_s;
      credit_r     <= credit_next_s;
    end
  end

  assign bus.last_grant      = last_grant_r;
  assign bus.priority_mask   = priority_mask_s;
  assign bus.burst_active    = burst_active_s;
  assign bus.burst_remaining = credit_r;

  br_wrr_state_internal_chk #(
    .NumRequesters (NumRequesters),
    .WeightWidth   (WeightWidth)
  ) u_chk (
    .clk             (clk),
    .rst             (rst),
    .update_priority (bus.update_priority),
    .grant           (bus.grant),
    .last_grant      (last_grant_r),
    .priority_mask   (priority_mask_s),
    .burst_active    (burst_active_s),
    .credit          (credit_r)
  );
endmodule

// File: tb/tb_br_wrr_state_internal.sv
module tb_br_wrr_state_internal;
  localparam int N  = 4;
  localparam int WW = 4;

  typedef struct {
    logic [N-1:0]  lg;
    logic [N-1:0]  mask;
    logic          ba;
    logic [WW-1:0] rem;
  } exp_t;

  logic clk;
  logic rst;
  br_wrr_state_internal_if #(.NumRequesters(N), .WeightWidth(WW)) bus ();

  br_wrr_state_internal #(.NumRequesters(N), .WeightWidth(WW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  event chk_ev;

  // Reference model: index of last winner and remaining extra grants.
  int            m_k;
  int            m_credit;
  logic [WW-1:0] wts[N];

  function automatic exp_t model_out();
    exp_t e;
    e.lg  = '0;
    e.lg[m_k] = 1'b1;
    e.ba  = (m_credit != 0);
    e.rem = WW'(m_credit);
    for (int i = 0; i < N; i++) begin
      e.mask[i] = e.ba ? (i < m_k) : (i <= m_k);
    end
    return e;
  endfunction

  task automatic model_reset();
    m_k      = N - 1;
    m_credit = 0;
  endtask

  task automatic model_step(input logic r, input logic u, input int j, input logic bc);
    if (r) begin
      model_reset();
    end else begin
      if (u) begin
        if (j == m_k && m_credit != 0) m_credit = m_credit - 1;
        else begin
          m_k      = j;
          m_credit = int'(wts[j]);
        end
      end
      if (bc) m_credit = 0;
    end
  endtask

  // One clock of stimulus: drive at negedge, advance model at posedge, queue result.
  task automatic cyc(input logic r, input logic u, input int j, input logic bc);
    logic [N-1:0] g;
    @(negedge clk);
    g = '0;
    if (u) g[j] = 1'b1;
    else   g = N'($urandom);
    rst                 = r;
    bus.update_priority = u;
    bus.grant           = g;
    bus.burst_clear     = bc;
    for (int i = 0; i < N; i++) bus.weight[i*WW +: WW] = wts[i];
    @(posedge clk);
    model_step(r, u, j, bc);
    exp_q.push_back(model_out());
  endtask

  // Reset asserted between edges; outputs must change without a clock edge.
  task automatic mid_reset();
    @(negedge clk);
    bus.update_priority = 1'b0;
    bus.burst_clear     = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    exp_q.push_back(model_out());
    ->chk_ev;
  endtask

  // Monitor: compares queued expectations against the DUT outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.last_grant !== e.lg) begin
          n_err++;
          $display("FAIL last_grant t=%0t got %b exp %b", $time, bus.last_grant, e.lg);
        end
        n_cmp++;
        if (bus.priority_mask !== e.mask) begin
          n_err++;
          $display("FAIL priority_mask t=%0t got %b exp %b", $time, bus.priority_mask, e.mask);
        end
        n_cmp++;
        if (bus.burst_active !== e.ba) begin
          n_err++;
          $display("FAIL burst_active t=%0t got %b exp %b", $time, bus.burst_active, e.ba);
        end
        n_cmp++;
        if (bus.burst_remaining !== e.rem) begin
          n_err++;
          $display("FAIL burst_remaining t=%0t got %0d exp %0d", $time, bus.burst_remaining, e.rem);
        end
      end
    end
  end

  initial begin
    int j;
    rst                 = 1'b1;
    bus.update_priority = 1'b0;
    bus.grant           = '0;
    bus.burst_clear     = 1'b0;
    bus.weight          = '0;
    for (int i = 0; i < N; i++) wts[i] = '0;
    model_reset();

    // Reset values.
    cyc(1'b1, 1'b0, 0, 1'b0);
    cyc(1'b0, 1'b0, 0, 1'b0);

    // All weights zero: plain round-robin.
    for (int i = 0; i < N; i++) cyc(1'b0, 1'b1, i, 1'b0);

    // weight[1]=2: three grants drain the burst, the fourth reloads it.
    wts[1] = 4'd2;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1, 1'b0);

    // Burst to 2 interrupted by a grant to 0.
    wts[2] = 4'd3;
    cyc(1'b0, 1'b1, 2, 1'b0);
    cyc(1'b0, 1'b1, 0, 1'b0);

    // Burst to 3: clear alone, then clear together with a grant.
    wts[3] = 4'd5;
    cyc(1'b0, 1'b1, 3, 1'b0);
    cyc(1'b0, 1'b0, 0, 1'b1);
    cyc(1'b0, 1'b1, 3, 1'b0);
    cyc(1'b0, 1'b1, 3, 1'b1);

    // Weight change mid-burst does not touch the running credit.
    cyc(1'b0, 1'b1, 3, 1'b0);
    wts[3] = 4'd1;
    cyc(1'b0, 1'b1, 3, 1'b0);
    cyc(1'b0, 1'b0, 0, 1'b0);

    // Async reset mid-burst, then a fresh maximum-weight burst.
    wts[1] = 4'd15;
    cyc(1'b0, 1'b1, 1, 1'b0);
    cyc(1'b0, 1'b1, 1, 1'b0);
    mid_reset();
    cyc(1'b1, 1'b0, 0, 1'b0);
    cyc(1'b0, 1'b1, 1, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 1, 1'b0);

    // Randomized traffic, biased toward repeating the current holder.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        for (int i = 0; i < N; i++) wts[i] = WW'($urandom);
      end
      j = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N-1)) : m_k;
      cyc(1'b0, ($urandom_range(0, 4) != 0), j, ($urandom_range(0, 9) == 0));
    end

    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain pending=%0d exp 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
